// File: rtl/bf_pkg.sv
// Shared Brainfuck definitions: opcode byte values and the program-memory load FSM states.
package bf_pkg;

   localparam logic [7:0] OP_INC   = 8'h2B;
   localparam logic [7:0] OP_DEC   = 8'h2D;
   localparam logic [7:0] OP_RIGHT = 8'h3E;
   localparam logic [7:0] OP_LEFT  = 8'h3C;
   localparam logic [7:0] OP_OUT   = 8'h2E;
   localparam logic [7:0] OP_IN    = 8'h2C;
   localparam logic [7:0] OP_LOOP  = 8'h5B;
   localparam logic [7:0] OP_END   = 8'h5D;
   localparam logic [7:0] OP_HALT  = 8'h00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bf_prog_ram.sv
// DEPTH x 8 program store: one synchronous write port, one synchronous read port.
module bf_prog_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [7:0] mem [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/bf_prog_mem.sv
// Loadable Brainfuck program memory: valid/ready byte loader, 1-cycle fetch port.
// Optional bracket-balance checker built when BF_BRACKET_CHECK_EN is defined.
module bf_prog_mem
   import bf_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [7:0]        load_data,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              load_done,
   output logic              load_ovf,
   output logic              busy,
   output logic [ADDR_W-1:0] prog_len,
   input  logic [ADDR_W-1:0] addrIn,
   output logic [7:0]        dataOut,
   output logic              bracket_err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] prog_len_q, prog_len_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;
   logic              fetch_ok_q, fetch_ok_d;

   logic              accept;
   logic              at_last;
   logic [7:0]        eff_byte;
   logic              we;
   logic [7:0]        ram_rdata;

   // A start pulse in LOAD wins over any byte presented that cycle.
   assign accept   = (state_q == LOAD) && load_valid && !load_start;
   assign at_last  = (wptr_q == LAST_ADDR);
   assign eff_byte = at_last ? OP_HALT : load_data;

   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      prog_len_d = prog_len_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      we         = 1'b0;
      if (load_start) begin
         state_d    = LOAD;
         wptr_d     = '0;
         prog_len_d = '0;
         ovf_d      = 1'b0;
      end else if (accept) begin
         we     = 1'b1;
         wptr_d = wptr_q + 1'b1;
         if (eff_byte != OP_HALT) begin
            prog_len_d = prog_len_q + 1'b1;
         end else begin
            state_d = DONE;
            done_d  = 1'b1;
            ovf_d   = at_last && (load_data != OP_HALT);
         end
      end
      fetch_ok_d = (state_q == DONE) && (addrIn < prog_len_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         wptr_q     <= '0;
         prog_len_q <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         fetch_ok_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         prog_len_q <= prog_len_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         fetch_ok_q <= fetch_ok_d;
      end
   end

   bf_prog_ram #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk  (clk),
      .we   (we),
      .waddr(wptr_q),
      .wdata(eff_byte),
      .raddr(addrIn),
      .rdata(ram_rdata)
   );

`ifdef BF_BRACKET_CHECK_EN
   logic [ADDR_W-1:0] depth_q, depth_d;
   logic              berr_q, berr_d;

   always_comb begin
      depth_d = depth_q;
      berr_d  = berr_q;
      if (load_start) begin
         depth_d = '0;
         berr_d  = 1'b0;
      end else if (accept) begin
         if (eff_byte == OP_LOOP) begin
            depth_d = depth_q + 1'b1;
         end else if (eff_byte == OP_END) begin
            // An unmatched ']' flags the error but leaves depth pinned at zero.
            if (depth_q == '0) berr_d = 1'b1;
            else               depth_d = depth_q - 1'b1;
         end else if ((eff_byte == OP_HALT) && (depth_q != '0)) begin
            berr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         depth_q <= '0;
         berr_q  <= 1'b0;
      end else begin
         depth_q <= depth_d;
         berr_q  <= berr_d;
      end
   end

   assign bracket_err = berr_q;
`else
   assign bracket_err = 1'b0;
`endif

   assign load_ready = (state_q == LOAD);
   assign busy       = (state_q == LOAD);
   assign load_done  = done_q;
   assign load_ovf   = ovf_q;
   assign prog_len   = prog_len_q;
   assign dataOut    = fetch_ok_q ? ram_rdata : OP_HALT;

endmodule

// File: tb/tb_bf_prog_mem.sv
// Bench for bf_prog_mem (ADDR_W=4): directed and random program loads against a array-based model.
module tb_bf_prog_mem;

   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          load_start = 1'b0;
   logic [7:0]    load_data = 8'h00;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic          load_done;
   logic          load_ovf;
   logic          busy;
   logic [AW-1:0] prog_len;
   logic [AW-1:0] addrIn = '0;
   logic [7:0]    dataOut;
   logic          bracket_err;

   int errors = 0;
   int checks = 0;

   bf_prog_mem #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_done  (load_done),
      .load_ovf   (load_ovf),
      .busy       (busy),
      .prog_len   (prog_len),
      .addrIn     (addrIn),
      .dataOut    (dataOut),
      .bracket_err(bracket_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input int a, output logic [7:0] d);
      addrIn = AW'(a);
      tick();
      d = dataOut;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   // Presents bytes in order until the memory stops being ready; counts handshakes.
   task automatic feed(input logic [7:0] prog[$], input bit rnd, output int consumed, output bit timeout);
      int idx = 0;
      int cyc = 0;
      bit hs;
      timeout = 1'b0;
      while (load_ready && idx < prog.size()) begin
         if (cyc >= 400) begin
            timeout = 1'b1;
            break;
         end
         load_data  = prog[idx];
         load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         hs = load_valid && load_ready;
         tick();
         if (hs) idx++;
         cyc++;
      end
      load_valid = 1'b0;
      consumed   = idx;
   endtask

   // Reference: what a loaded memory should hold after streaming prog.
   task automatic model(input logic [7:0] prog[$], output logic [7:0] m[DEPTH],
                        output int n, output int len, output bit ovf, output bit berr);
      int depth = 0;
      n = 0; len = 0; ovf = 1'b0; berr = 1'b0;
      for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;
      for (int i = 0; i < prog.size() && i < DEPTH; i++) begin
         n = i + 1;
         if (i == DEPTH - 1) begin
            ovf = (prog[i] != 8'h00);
            break;
         end
         m[i] = prog[i];
         if (prog[i] == 8'h00) break;
         len++;
      end
      for (int i = 0; i < len; i++) begin
         if (m[i] == 8'h5B) depth++;
         else if (m[i] == 8'h5D) begin
            if (depth == 0) berr = 1'b1;
            else depth--;
         end
      end
      if (depth != 0) berr = 1'b1;
   endtask

   task automatic test_program(input string name, input logic [7:0] prog[$], input bit rnd);
      logic [7:0] em[DEPTH];
      int en, elen, cons;
      bit eovf, eberr, to;
      logic [7:0] d, ed;
      model(prog, em, en, elen, eovf, eberr);
`ifndef BF_BRACKET_CHECK_EN
      eberr = 1'b0;
`endif
      start_load();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_in_load: got %b expected 1", name, busy); end
      feed(prog, rnd, cons, to);
      checks++;
      if (to || cons != en) begin errors++; $display("FAIL %s accepted: got %0d expected %0d (timeout=%0d)", name, cons, en, to); end
      checks++;
      if (load_done !== 1'b1) begin errors++; $display("FAIL %s load_done: got %b expected 1", name, load_done); end
      checks++;
      if (prog_len !== AW'(elen)) begin errors++; $display("FAIL %s prog_len: got %0d expected %0d", name, prog_len, elen); end
      checks++;
      if (load_ovf !== eovf) begin errors++; $display("FAIL %s load_ovf: got %b expected %b", name, load_ovf, eovf); end
      checks++;
      if (load_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s ready/busy after: got %b/%b expected 0/0", name, load_ready, busy); end
      checks++;
      if (bracket_err !== eberr) begin errors++; $display("FAIL %s bracket_err: got %b expected %b", name, bracket_err, eberr); end
      for (int a = 0; a < DEPTH; a++) begin
         fetch(a, d);
         if (a == 0) begin
            checks++;
            if (load_done !== 1'b0) begin errors++; $display("FAIL %s load_done_pulse: got %b expected 0", name, load_done); end
         end
         ed = (a < elen) ? em[a] : 8'h00;
         checks++;
         if (d !== ed) begin errors++; $display("FAIL %s fetch[%0d]: got %h expected %h", name, a, d, ed); end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      checks++;
      if ({load_ready, load_done, load_ovf, busy, bracket_err} !== 5'b0 || prog_len !== '0 || dataOut !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b done=%b ovf=%b busy=%b berr=%b len=%0d dout=%h expected all 0",
                  load_ready, load_done, load_ovf, busy, bracket_err, prog_len, dataOut);
      end
   endtask

   task automatic test_basic();
      logic [7:0] p[$] = '{8'h2B, 8'h5B, 8'h2B, 8'h5D, 8'h3E, 8'h2D, 8'h5B, 8'h2D, 8'h5D, 8'h00};
      test_program("basic", p, 1'b0);
   endtask

   task automatic test_overflow();
      logic [7:0] p[$];
      for (int i = 0; i < 20; i++) p.push_back(8'h2B);
      test_program("overflow", p, 1'b0);
   endtask

   task automatic test_valid_toggle();
      logic [7:0] p[$] = '{8'h2B, 8'h2B, 8'h3E, 8'h00};
      test_program("valid_toggle", p, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      start_load();
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h2B;
         tick();
      end
      load_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || prog_len !== '0 || load_ready !== 1'b0 || load_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b len=%0d rdy=%b ovf=%b expected 0/0/0/0", busy, prog_len, load_ready, load_ovf);
      end
      fetch(0, d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL reset_mid_fetch: got %h expected 00", d); end
   endtask

   task automatic test_restart();
      logic [7:0] p[$] = '{8'h2D, 8'h3C, 8'h00};
      logic [7:0] d;
      int cons;
      bit to;
      start_load();
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = 8'h2B;
         tick();
      end
      checks++;
      if (prog_len !== AW'(3)) begin errors++; $display("FAIL restart_pre_len: got %0d expected 3", prog_len); end
      // Restart with a terminator on the bus: it must be dropped, not end the load.
      load_start = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h00;
      tick();
      load_start = 1'b0;
      load_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || prog_len !== '0 || load_done !== 1'b0) begin
         errors++;
         $display("FAIL restart_state: got busy=%b len=%0d done=%b expected 1/0/0", busy, prog_len, load_done);
      end
      feed(p, 1'b0, cons, to);
      checks++;
      if (to || cons != 3 || prog_len !== AW'(2) || load_done !== 1'b1) begin
         errors++;
         $display("FAIL restart_load: got acc=%0d len=%0d done=%b expected 3/2/1", cons, prog_len, load_done);
      end
      for (int a = 0; a < 4; a++) begin
         fetch(a, d);
         checks++;
         if (d !== ((a < 2) ? p[a] : 8'h00)) begin
            errors++;
            $display("FAIL restart_fetch[%0d]: got %h expected %h", a, d, (a < 2) ? p[a] : 8'h00);
         end
      end
   endtask

   task automatic test_brackets();
      logic [7:0] p1[$] = '{8'h5D, 8'h5B, 8'h00};
      logic [7:0] p2[$] = '{8'h5B, 8'h5B, 8'h5D, 8'h5D, 8'h00};
      logic [7:0] p3[$] = '{8'h5B, 8'h5B, 8'h00};
      test_program("br_close_open", p1, 1'b0);
      test_program("br_nested", p2, 1'b0);
      test_program("br_unclosed", p3, 1'b1);
   endtask

   task automatic test_random();
      logic [7:0] ops[8] = '{8'h2B, 8'h2D, 8'h3E, 8'h3C, 8'h2E, 8'h2C, 8'h5B, 8'h5D};
      for (int t = 0; t < 8; t++) begin
         logic [7:0] p[$];
         int len = $urandom_range(0, 20);
         for (int i = 0; i < len; i++) p.push_back(ops[$urandom_range(0, 7)]);
         p.push_back(8'h00);
         test_program($sformatf("random%0d", t), p, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_reset_mid();
      test_valid_toggle();
      test_restart();
      test_brackets();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
